// File: rtl/spi_follower.sv
// spi_follower: SPI target endpoint driven by an external leader.
// Ports:
//   clk, rst (async, active-low)          system clock / reset
//   cpol, cpha, len16                     frame mode, latched at frame start
//   sclk_in, cs_n_in, mosi                asynchronous leader-side inputs
//   miso, miso_oe                         serial data out and pad enable
//   tx_data, tx_valid, tx_ready           one-entry transmit buffer
//   rx_data, rx_valid, rx_ack             received-word holding register
//   busy, overrun                         frame in progress / sticky drop flag
// Optional build macro SPI_FOLLOWER_LSB_FIRST_EN: shift LSB-first in both directions.
module spi_follower #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] IDLE_FILL   = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpol,
  input  logic        cpha,
  input  logic        len16,
  input  logic        sclk_in,
  input  logic        cs_n_in,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  input  logic [15:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  input  logic        rx_ack,
  output logic        busy,
  output logic        overrun
);
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_e;
  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic                   cpol_q, cpha_q, len16_q;
  logic [15:0]            tx_buf_q, tx_sh_q, rx_sh_q, rx_data_q;
  logic                   tx_full_q, miso_q, miso_oe_q, rx_valid_q, busy_q, overrun_q;
  logic [4:0]             cnt_q;
  logic                   sclk_s, cs_s, mosi_s, cs_fall, rise, fall, lead, trail, smp, shf, last;
  logic [15:0]            fill_w, load_w, tx_sh_d, rx_sh_d;
  logic                   first_bit, miso_d;
  assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign cs_fall  = cs_prev_q & ~cs_s;
  assign rise     = sclk_s & ~sclk_prev_q;
  assign fall     = ~sclk_s & sclk_prev_q;
  assign lead     = cpol_q ? fall : rise;
  assign trail    = cpol_q ? rise : fall;
  assign smp      = cpha_q ? trail : lead;
  assign shf      = cpha_q ? lead : trail;
  assign last     = (cnt_q + 5'd1) == (len16_q ? 5'd16 : 5'd8);
  assign fill_w   = tx_full_q ? tx_buf_q : IDLE_FILL;
`ifdef SPI_FOLLOWER_LSB_FIRST_EN
  assign load_w    = len16 ? fill_w : {8'h00, fill_w[7:0]};
  assign first_bit = load_w[0];
  assign tx_sh_d   = tx_sh_q >> 1;
  assign miso_d    = tx_sh_q[1];
  // Bits land at their final index, so 8-bit frames need no realignment.
  assign rx_sh_d   = rx_sh_q | (16'(mosi_s) << cnt_q[3:0]);
`else
  // 8-bit words are parked in the upper byte so bit 15 is always the next bit out.
  assign load_w    = len16 ? fill_w : {fill_w[7:0], 8'h00};
  assign first_bit = load_w[15];
  assign tx_sh_d   = tx_sh_q << 1;
  assign miso_d    = tx_sh_q[14];
  assign rx_sh_d   = {rx_sh_q[14:0], mosi_s};
`endif
  assign miso     = miso_q;
  assign miso_oe  = miso_oe_q;
  assign tx_ready = ~tx_full_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sclk_sync_q <= {SYNC_STAGES{cpol}};
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= cpol;
      cs_prev_q   <= 1'b1;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      len16_q     <= 1'b0;
      tx_buf_q    <= '0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      rx_data_q   <= '0;
      tx_full_q   <= 1'b0;
      miso_q      <= 1'b1;
      miso_oe_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_in};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      if (rx_ack) rx_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (cs_fall) begin
          cpol_q    <= cpol;
          cpha_q    <= cpha;
          len16_q   <= len16;
          tx_sh_q   <= load_w;
          miso_q    <= first_bit;
          tx_full_q <= 1'b0;
          cnt_q     <= '0;
          rx_sh_q   <= '0;
          busy_q    <= 1'b1;
          miso_oe_q <= 1'b1;
          state_q   <= ACTIVE;
        end
        ACTIVE: if (cs_s) state_q <= IDLE;
        else begin
          if (smp) begin
            rx_sh_q <= rx_sh_d;
            cnt_q   <= cnt_q + 5'd1;
            if (last) state_q <= DONE;
          end
          // With cpha=1 the first leading edge only presents the bit already on miso.
          if (shf && cnt_q != 5'd0) begin
            tx_sh_q <= tx_sh_d;
            miso_q  <= miso_d;
          end
        end
        DONE: begin
          if (!rx_valid_q || rx_ack) begin
            rx_data_q  <= rx_sh_q;
            rx_valid_q <= 1'b1;
          end else overrun_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      // A capture after a same-cycle frame start refills the buffer for the next frame.
      if (tx_valid && !tx_full_q) begin
        tx_buf_q  <= tx_data;
        tx_full_q <= 1'b1;
      end
      if (cs_s) begin
        busy_q    <= 1'b0;
        miso_oe_q <= 1'b0;
      end
    end
  end
endmodule

// File: doc/spi_follower.md
Name: spi_follower

Overview:
- Dedicated SPI follower (target) endpoint: the far end of the leader-mode link driven by the SPI top.
- Receives the external serial clock, chip select and data-in from a leader, then shifts a preloaded transmit word out on miso while capturing mosi.
- Presents received words to the local CPU side through a valid/ack holding register; transmit words are accepted through a valid/ready buffer.
- Supports all four CPOL/CPHA modes and 8- or 16-bit frames, matching the leader configuration fields.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the synchronizers on sclk_in, cs_n_in and mosi (minimum 2).
- IDLE_FILL, 16'hFFFF, word shifted out when no transmit word is buffered at frame start.

Ports:
- clk  input  1  system clock; all logic is in this domain.
- rst  input  1  asynchronous, active-low reset.
- cpol  input  1  clock polarity; idle level of sclk_in.
- cpha  input  1  clock phase; 0 = sample on leading edge, 1 = sample on trailing edge.
- len16  input  1  frame length select; 1 = 16 bits, 0 = 8 bits.
- sclk_in  input  1  serial clock from the leader; asynchronous.
- cs_n_in  input  1  active-low chip select from the leader; asynchronous.
- mosi  input  1  serial data from the leader.
- miso  output  1  serial data to the leader.
- miso_oe  output  1  output enable for the miso pad.
- tx_data  input  16  transmit word; bits [7:0] only when len16=0.
- tx_valid  input  1  transmit word offered.
- tx_ready  output  1  transmit buffer empty.
- rx_data  output  16  last received word, zero-extended for 8-bit frames.
- rx_valid  output  1  rx_data holds an unread word.
- rx_ack  input  1  consumer has read rx_data.
- busy  output  1  frame in progress.
- overrun  output  1  sticky: a frame completed while rx_valid was still set.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. Outputs: miso=1, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, overrun=0. The tx buffer is emptied and all synchronizers are set to idle (cs high, sclk equal to the cpol level).
- Synchronizers: sclk_in, cs_n_in and mosi each pass through SYNC_STAGES flops. Edges are detected on the synchronized sclk by comparing it with a one-cycle-delayed copy. sclk_in must run at most clk/8.
- Leading edge: the rising edge when cpol=0, the falling edge when cpol=1. The trailing edge is the opposite.
- Transmit buffer: when tx_valid and tx_ready are both high, tx_data is captured and tx_ready drops on the next clk. A buffered word is never overwritten.
- State IDLE: on a synchronized cs falling edge, the block:
  - latches cpol, cpha and len16 for the whole frame;
  - loads the shift register from the buffer (or IDLE_FILL if the buffer is empty);
  - empties the buffer (tx_ready=1 on the next clk);
  - clears the bit counter;
  - sets busy=1 and miso_oe=1;
  - drives the MSB on miso;
  - moves to ACTIVE.
- State ACTIVE, cpha=0: sample mosi on each leading edge; shift out the next bit on each trailing edge.
- State ACTIVE, cpha=1: shift on each leading edge (the first leading edge presents the MSB); sample on each trailing edge.
- Bit counter: 5 bits, incremented per sample. When it reaches 8 or 16 (per the latched len16), move to DONE.
- State DONE, one clk:
  - If rx_valid=0 or rx_ack=1 in the same cycle: rx_data is loaded with the assembled word and rx_valid=1.
  - Otherwise: rx_data is kept, overrun is set, and the new word is dropped.
  - Then return to IDLE; busy falls when cs rises.
- Latency: rx_valid rises 2 clk after the detected final sampling edge.
- rx_ack with no new completion clears rx_valid on the next clk. overrun clears only on reset.
- cs rises mid-frame (ACTIVE): abort. The partial word is discarded, rx_valid and overrun are unchanged, the tx word is consumed (not restored), and the block returns to IDLE. miso_oe=0 and busy=0 one clk after the synchronized cs rise.
- sclk edges while cs is high are ignored. cpol, cpha and len16 changes mid-frame have no effect.
- miso holds its last bit between edges. miso_oe is low whenever the synchronized cs is high.

Optional Feature:
- Macro SPI_FOLLOWER_LSB_FIRST_EN.
- Defined: both the tx and rx shift directions are LSB-first. Bit 0 is driven first; the first sampled bit lands in bit 0.
- Undefined: MSB-first, as described above.
- Port list is identical in both builds.

Test Plan:
- Mode 0, len16=0, tx 8'hA5 preloaded, leader sends 8'h3C at clk/8 -> miso carries 1,0,1,0,0,1,0,1; rx_data=16'h003C; rx_valid=1; tx_ready=1.
- Mode 3, len16=1, tx 16'hBEEF, leader sends 16'h1234 -> miso carries BEEF MSB-first, with the first bit valid after the first leading edge; rx_data=16'h1234.
- Modes 1 and 2, 8-bit, with no tx word buffered -> miso carries 8'hFF (IDLE_FILL); rx captures 8'h81 correctly in both modes.
- Two back-to-back 8-bit frames (8'h11 then 8'h22) without rx_ack -> rx_data stays 8'h11 and overrun=1. Repeat with rx_ack asserted in the second DONE cycle -> rx_data=8'h22 and overrun=0.
- Abort: cs rises after 5 bits of 8'hF0 -> no rx_valid, busy=0 and miso_oe=0 within SYNC_STAGES+2 clk. The next full frame of 8'h5A is received correctly.
- Reset asserted mid-frame -> all outputs return to reset values immediately. After release, tx_ready=1 and no stale rx_valid.
